hdc_am_search: RTL and testbench

- Decode side of the HDC bind stage, which forms OUT_i = FC_i ^ (POS ^ IN).
- Accepts a query hypervector and its position vector, and unbinds them (XOR is self-inverse).
- Sequentially scores the unbound query against R stored class hypervectors held in an external synchronous memory, using chunked Hamming distance.
- Returns the index and distance of the nearest class; sits after the encoder as the associative-memory classifier.

---
 rtl/hdc_am_search.sv | 168 ++++++++++++++++
 tb/tb_hdc_am_search.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/hdc_am_search.sv
// hdc_am_search: associative-memory classifier that follows the HDC encoder.
//
// A query arrives in its bound form together with its position vector. The
// two are XORed to recover the unbound query q, which is then compared with
// each of R class hypervectors read one at a time from an external
// synchronous memory. Each comparison is a Hamming distance computed CHUNK
// bits per cycle. The index and distance of the nearest class are returned.
//
// Ports
//   sysclk, rst          clock, synchronous active-high reset
//   in_valid/in_ready    query handshake; in_hv (bound query), in_pos (position)
//   cls_rd/cls_addr      class memory read strobe and index
//   cls_data             class hypervector, valid the cycle after cls_rd
//   out_valid/out_ready  result handshake; out_class, out_dist
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | ready for a query; unbind and latch it on transfer
// FETCH   | one-cycle read strobe for class k
// CAPTURE | latch cls_data ^ q, clear accumulator and chunk counter
// ACC     | add popcount of one CHUNK-bit slice per cycle, N cycles
// CMP     | keep class k if strictly closer; next class or finish
// DONE    | present result until the consumer takes it
module hdc_am_search #(
    parameter int L     = 1000,
    parameter int R     = 100,
    parameter int CHUNK = 100,
    localparam int N    = L / CHUNK,
    localparam int AW   = (R > 1) ? $clog2(R) : 1,
    localparam int DW   = $clog2(L + 1),
    localparam int CW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic          sysclk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [L-1:0]  in_hv,
    input  logic [L-1:0]  in_pos,
    output logic          cls_rd,
    output logic [AW-1:0] cls_addr,
    input  logic [L-1:0]  cls_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_class,
    output logic [DW-1:0] out_dist
);

    typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, ACC, CMP, DONE} state_t;

    state_t        state, state_nxt;
    logic [L-1:0]  q;
    logic [L-1:0]  diff;
    logic [DW-1:0] acc;
    logic [DW-1:0] best_dist;
    logic [AW-1:0] best_idx;
    logic [AW-1:0] k;
    logic [CW-1:0] c;
    logic [AW-1:0] out_class_r;
    logic [DW-1:0] out_dist_r;
    logic          c_last;
    logic          k_last;
    logic          closer;

    function automatic logic [DW-1:0] popcnt(input logic [CHUNK-1:0] v);
        logic [DW-1:0] s;
        s = '0;
        for (int i = 0; i < CHUNK; i++) begin
            s = s + DW'(v[i]);
        end
        return s;
    endfunction

    assign c_last = (c == CW'(N - 1));
    assign k_last = (k == AW'(R - 1));
    assign closer = (acc < best_dist);

    // k only changes on edges that enter FETCH (or on reset), so it doubles
    // as the read address and naturally holds between reads.
    assign cls_addr  = k;
    assign out_class = out_class_r;
    assign out_dist  = out_dist_r;

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        cls_rd    = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = FETCH;
            end
            FETCH: begin
                cls_rd    = 1'b1;
                state_nxt = CAPTURE;
            end
            CAPTURE: state_nxt = ACC;
            ACC: begin
                if (c_last) state_nxt = CMP;
            end
            CMP: state_nxt = k_last ? DONE : FETCH;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The difference vector is shifted down one chunk per ACC cycle so the
    // popcount always looks at the low CHUNK bits; no variable slicing needed.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            q           <= '0;
            diff        <= '0;
            acc         <= '0;
            best_dist   <= '1;
            best_idx    <= '0;
            k           <= '0;
            c           <= '0;
            out_class_r <= '0;
            out_dist_r  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        q         <= in_hv ^ in_pos;
                        k         <= '0;
                        best_dist <= '1;
                        best_idx  <= '0;
                    end
                end
                CAPTURE: begin
                    diff <= cls_data ^ q;
                    acc  <= '0;
                    c    <= '0;
                end
                ACC: begin
                    acc  <= acc + popcnt(diff[CHUNK-1:0]);
                    diff <= diff >> CHUNK;
                    c    <= c_last ? '0 : c + 1'b1;
                end
                CMP: begin
                    if (closer) begin
                        best_dist <= acc;
                        best_idx  <= k;
                    end
                    if (k_last) begin
                        out_class_r <= closer ? k : best_idx;
                        out_dist_r  <= closer ? acc : best_dist;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hdc_am_search.sv
// Testbench for hdc_am_search: a small instance (L=8, R=4, CHUNK=4) exercised
// with hand-computed directed queries, and a default-sized instance searched
// for a planted class.
module tb_hdc_am_search;

    logic sysclk = 1'b0;
    logic rst;

    always #5 sysclk = ~sysclk;

    // small instance
    logic       in_valid, in_ready, cls_rd, out_valid, out_ready;
    logic [7:0] in_hv, in_pos, cls_data;
    logic [1:0] cls_addr, out_class;
    logic [3:0] out_dist;
    logic [7:0] smem [4];

    // default-sized instance
    logic         b_in_valid, b_in_ready, b_cls_rd, b_out_valid, b_out_ready;
    logic [999:0] b_in_hv, b_in_pos, b_cls_data;
    logic [6:0]   b_cls_addr, b_out_class;
    logic [9:0]   b_out_dist;
    logic [999:0] bmem [100];

    int nerr = 0;
    int nchecks = 0;
    int rd_addrs[$];

    hdc_am_search #(.L(8), .R(4), .CHUNK(4)) dut_s (
        .sysclk(sysclk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_hv(in_hv), .in_pos(in_pos),
        .cls_rd(cls_rd), .cls_addr(cls_addr), .cls_data(cls_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_class(out_class), .out_dist(out_dist)
    );

    hdc_am_search dut_b (
        .sysclk(sysclk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_hv(b_in_hv), .in_pos(b_in_pos),
        .cls_rd(b_cls_rd), .cls_addr(b_cls_addr), .cls_data(b_cls_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_class(b_out_class), .out_dist(b_out_dist)
    );

    // synchronous class memories: data valid the cycle after the strobe
    always @(posedge sysclk) begin
        if (cls_rd) cls_data <= smem[cls_addr];
        if (b_cls_rd) b_cls_data <= bmem[b_cls_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nchecks++;
        if (obs !== expv) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    // Present one query to the small instance and count edges from the
    // accept edge to the first cycle with out_valid high.
    task automatic run_small(input logic [7:0] hv, input logic [7:0] pos, output int lat);
        check("s_accept_ready", 32'(in_ready), 32'd1);
        in_hv = hv;
        in_pos = pos;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_hv = 8'h00;
        in_pos = 8'h00;
        rd_addrs.delete();
        lat = 0;
        while (!out_valid && lat < 200) begin
            if (cls_rd) rd_addrs.push_back(int'(cls_addr));
            tick();
            lat++;
        end
    endtask

    task automatic run_big(input logic [999:0] hv, input logic [999:0] pos, output int lat);
        check("b_accept_ready", 32'(b_in_ready), 32'd1);
        b_in_hv = hv;
        b_in_pos = pos;
        b_in_valid = 1'b1;
        tick();
        b_in_valid = 1'b0;
        lat = 0;
        while (!b_out_valid && lat < 2000) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [999:0] pos, hv;

        smem[0] = 8'h00;
        smem[1] = 8'hFF;
        smem[2] = 8'h0F;
        smem[3] = 8'h3C;
        for (int i = 0; i < 100; i++)
            for (int j = 0; j < 1000; j++)
                bmem[i][j] = 1'($urandom_range(0, 1));

        rst = 1'b1;
        in_valid = 1'b0;   in_hv = '0;   in_pos = '0;   out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_hv = '0; b_in_pos = '0; b_out_ready = 1'b1;
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_cls_rd", 32'(cls_rd), 32'd0);
        check("rst_cls_addr", 32'(cls_addr), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_class", 32'(out_class), 32'd0);
        check("rst_out_dist", 32'(out_dist), 32'd0);
        rst = 1'b0;
        tick();

        // 1: q = 0x00, exact match on class 0
        run_small(8'h5A, 8'h5A, lat);
        check("t1_latency", 32'(lat), 32'd20);
        check("t1_class", 32'(out_class), 32'd0);
        check("t1_dist", 32'(out_dist), 32'd0);
        tick();
        check("t1_out_valid_drop", 32'(out_valid), 32'd0);
        check("t1_in_ready_back", 32'(in_ready), 32'd1);

        // 2: q = 0xF0, distances 4,4,8,4 -> lowest index wins the tie
        run_small(8'hF0, 8'h00, lat);
        check("t2_latency", 32'(lat), 32'd20);
        check("t2_class", 32'(out_class), 32'd0);
        check("t2_dist", 32'(out_dist), 32'd4);
        tick();

        // 3: q = 0x3C, exact match on the last class; one read per class
        run_small(8'hC3, 8'hFF, lat);
        check("t3_class", 32'(out_class), 32'd3);
        check("t3_dist", 32'(out_dist), 32'd0);
        check("t3_rd_pulses", 32'(rd_addrs.size()), 32'd4);
        for (int i = 0; i < rd_addrs.size() && i < 4; i++)
            check($sformatf("t3_rd_addr%0d", i), 32'(rd_addrs[i]), 32'(i));
        tick();

        // 4: q = 0xFF -> class 1 dist 0; result held while out_ready is low
        out_ready = 1'b0;
        run_small(8'hF0, 8'h0F, lat);
        check("t4_latency", 32'(lat), 32'd20);
        for (int i = 0; i < 10; i++) begin
            in_valid = (i == 3 || i == 4);
            in_hv = 8'h00;
            tick();
            check($sformatf("t4_hold%0d", i),
                  32'({out_valid, in_ready, out_class, out_dist}),
                  32'({1'b1, 1'b0, 2'd1, 4'd0}));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("t4_out_valid_drop", 32'(out_valid), 32'd0);
        check("t4_in_ready_back", 32'(in_ready), 32'd1);
        check("t4_no_new_read", 32'(cls_rd), 32'd0);

        // 5: reset during ACC of class 2 of a q=0x00 search, then q=0xF0
        in_hv = 8'h00;
        in_pos = 8'h00;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (12) tick();
        check("t5_at_class2", 32'(cls_addr), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_rst_in_ready", 32'(in_ready), 32'd1);
        check("t5_rst_out_valid", 32'(out_valid), 32'd0);
        check("t5_rst_cls_rd", 32'(cls_rd), 32'd0);
        run_small(8'hF0, 8'h00, lat);
        check("t5_latency", 32'(lat), 32'd20);
        check("t5_class", 32'(out_class), 32'd0);
        check("t5_dist", 32'(out_dist), 32'd4);
        tick();

        // 6: default size, query is the bound form of class 57
        for (int j = 0; j < 1000; j++) pos[j] = 1'($urandom_range(0, 1));
        hv = bmem[57] ^ pos;
        run_big(hv, pos, lat);
        check("t6_latency", 32'(lat), 32'd1300);
        check("t6_class", 32'(b_out_class), 32'd57);
        check("t6_dist", 32'(b_out_dist), 32'd0);
        tick();

        // same class with three bits flipped across chunk boundaries
        hv[0] = ~hv[0];
        hv[500] = ~hv[500];
        hv[999] = ~hv[999];
        run_big(hv, pos, lat);
        check("t6b_latency", 32'(lat), 32'd1300);
        check("t6b_class", 32'(b_out_class), 32'd57);
        check("t6b_dist", 32'(b_out_dist), 32'd3);
        tick();

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
